// File: rtl/msrv32_store_buffer_if.sv
// rtl/msrv32_store_buffer_if.sv - store buffer signal bundle (store unit, load check, AHB-Lite write port)
// slave modport: the store buffer itself. master modport: store unit / bus / checker side.
//  st_valid_in/st_addr_in/st_data_in/st_mask_in/st_ready_out : store push handshake
//  ld_addr_in/ld_hit_out                                      : load word-address hazard check
//  empty_out                                                  : nothing queued or in flight
//  haddr_out/htrans_out/hwrite_out/hsize_out/hwdata_out       : AHB-Lite master write outputs
//  hready_in/hresp_in                                         : AHB-Lite slave response
//  err_out/err_addr_out                                       : errored-write pulse and captured address
interface msrv32_store_buffer_if;
    logic        st_valid_in;
    logic [31:0] st_addr_in;
    logic [31:0] st_data_in;
    logic [3:0]  st_mask_in;
    logic        st_ready_out;
    logic [31:0] ld_addr_in;
    logic        ld_hit_out;
    logic        empty_out;
    logic [31:0] haddr_out;
    logic [1:0]  htrans_out;
    logic        hwrite_out;
    logic [2:0]  hsize_out;
    logic [31:0] hwdata_out;
    logic        hready_in;
    logic        hresp_in;
    logic        err_out;
    logic [31:0] err_addr_out;

    modport slave (
        input  st_valid_in, st_addr_in, st_data_in, st_mask_in, ld_addr_in, hready_in, hresp_in,
        output st_ready_out, ld_hit_out, empty_out, haddr_out, htrans_out, hwrite_out,
               hsize_out, hwdata_out, err_out, err_addr_out
    );

    modport master (
        output st_valid_in, st_addr_in, st_data_in, st_mask_in, ld_addr_in, hready_in, hresp_in,
        input  st_ready_out, ld_hit_out, empty_out, haddr_out, htrans_out, hwrite_out,
               hsize_out, hwdata_out, err_out, err_addr_out
    );
endinterface

// File: rtl/msrv32_store_buffer.sv
// rtl/msrv32_store_buffer.sv - posted-write store buffer draining to AHB-Lite as single NONSEQ writes
// Ports: ms_riscv32_mp_clk_in (clock), ms_riscv32_mp_rst_n_in (async active-low reset),
//        sb (msrv32_store_buffer_if.slave: store push, load hazard check, AHB write port, error report).
// Optional feature: MSRV32_SB_ERR_CAPTURE_EN makes err_addr_out capture the first errored haddr (sticky).
module msrv32_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                 ms_riscv32_mp_clk_in,
    input  logic                 ms_riscv32_mp_rst_n_in,
    msrv32_store_buffer_if.slave sb
);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Entries between head_q and tail_q are un-issued; the one at head_q owns the
    // address phase. Once its address phase completes it moves into the data-phase
    // register, freeing the slot, so count_q = qcount_q + (state_q == S_DATA).
    logic [29:0]      addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [3:0]       mask_mem [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [PTR_W:0]   qcount_q, count_q;
    logic [31:0]      dph_addr_q, dph_data_q;
    logic             err_q;

    logic [5:0] head_dec;
    logic       push, pop, drop, nonseq, aph_done, retire, err_hold, ld_hit;
    logic       unused_bits;

    // {legal, hsize[2:0], haddr[1:0]}; illegal masks are dropped at issue
    function automatic logic [5:0] mask_decode(input logic [3:0] m);
        case (m)
            4'b0001: return {1'b1, 3'b000, 2'b00};
            4'b0010: return {1'b1, 3'b000, 2'b01};
            4'b0100: return {1'b1, 3'b000, 2'b10};
            4'b1000: return {1'b1, 3'b000, 2'b11};
            4'b0011: return {1'b1, 3'b001, 2'b00};
            4'b1100: return {1'b1, 3'b001, 2'b10};
            4'b1111: return {1'b1, 3'b010, 2'b00};
            default: return 6'b000000;
        endcase
    endfunction

    assign head_dec = mask_decode(mask_mem[head_q]);
    assign push     = sb.st_valid_in && (count_q != FULL);

    always_comb begin
        nonseq   = 1'b0;
        drop     = 1'b0;
        err_hold = 1'b0;
        aph_done = 1'b0;
        retire   = 1'b0;
        pop      = 1'b0;
        state_d  = state_q;

        // first error cycle: pull the pending address phase off the bus
        err_hold = (state_q == S_DATA) && sb.hresp_in && !sb.hready_in;
        if (qcount_q != '0) begin
            drop   = !head_dec[5];
            nonseq = head_dec[5] && !err_hold;
        end
        aph_done = nonseq && sb.hready_in;
        retire   = (state_q == S_DATA) && sb.hready_in;
        pop      = aph_done || drop;

        if (aph_done)
            state_d = S_DATA;
        else if ((state_q == S_DATA) && !sb.hready_in)
            state_d = S_DATA;
        else if (nonseq)
            state_d = S_ADDR;
        else
            state_d = S_IDLE;
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q    <= S_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            qcount_q   <= '0;
            count_q    <= '0;
            dph_addr_q <= '0;
            dph_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            if (push)
                tail_q <= tail_q + PTR_W'(1);
            if (pop)
                head_q <= head_q + PTR_W'(1);
            qcount_q <= qcount_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            count_q  <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(retire) - (PTR_W+1)'(drop);
            if (aph_done) begin
                dph_addr_q <= {addr_mem[head_q], head_dec[1:0]};
                dph_data_q <= data_mem[head_q];
            end
            err_q <= retire && sb.hresp_in;
        end
    end

    // storage needs no reset: occupancy is tracked by the pointers and counts
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (push) begin
            addr_mem[tail_q] <= sb.st_addr_in[31:2];
            data_mem[tail_q] <= sb.st_data_in;
            mask_mem[tail_q] <= sb.st_mask_in;
        end
    end

    always_comb begin
        ld_hit = (state_q == S_DATA) && (dph_addr_q[31:2] == sb.ld_addr_in[31:2]);
        for (int i = 0; i < DEPTH; i++) begin
            // slot i is live when its distance from head is below the queue count
            if (({1'b0, PTR_W'(PTR_W'(i) - head_q)} < qcount_q) &&
                (mask_mem[i] != 4'b0000) &&
                (addr_mem[i] == sb.ld_addr_in[31:2]))
                ld_hit = 1'b1;
        end
    end

`ifdef MSRV32_SB_ERR_CAPTURE_EN
    logic        err_seen_q;
    logic [31:0] err_addr_q;

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            err_seen_q <= 1'b0;
            err_addr_q <= '0;
        end else if (retire && sb.hresp_in && !err_seen_q) begin
            err_seen_q <= 1'b1;
            err_addr_q <= dph_addr_q;
        end
    end

    assign sb.err_addr_out = err_addr_q;
`else
    assign sb.err_addr_out = 32'h0;
`endif

    assign sb.st_ready_out = (count_q != FULL);
    assign sb.empty_out    = (count_q == '0);
    assign sb.ld_hit_out   = ld_hit;
    assign sb.htrans_out   = nonseq ? 2'b10 : 2'b00;
    assign sb.hwrite_out   = nonseq;
    assign sb.haddr_out    = nonseq ? {addr_mem[head_q], head_dec[1:0]} : 32'h0;
    assign sb.hsize_out    = nonseq ? head_dec[4:2] : 3'b000;
    assign sb.hwdata_out   = dph_data_q;
    assign sb.err_out      = err_q;

    assign unused_bits = ^{sb.st_addr_in[1:0], sb.ld_addr_in[1:0], dph_addr_q[1:0]};
endmodule
